mdc_delay_switch_stage: RTL and testbench

//  Full R2MDC inter-butterfly reorder stage: pre-delay on path 1, commutator switch, post-delay on path 0.

---
 rtl/mdc_delay_switch_stage_if.sv | 31 +++
 rtl/mdc_delay_switch_stage.sv | 111 +++++++++++
 tb/tb_mdc_delay_switch_stage.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdc_delay_switch_stage_if.sv
// Pair bus for the MDC delay/switch stage: one valid strobe plus two
// complex samples (path 0 = upper, path 1 = lower), re/im split per path.
//   valid        : pair present this cycle
//   x0_re, x0_im : path-0 sample
//   x1_re, x1_im : path-1 sample
// master drives the pair, slave consumes it.
interface mdc_delay_switch_stage_if #(
    parameter int DW = 16
);
    logic          valid;
    logic [DW-1:0] x0_re;
    logic [DW-1:0] x0_im;
    logic [DW-1:0] x1_re;
    logic [DW-1:0] x1_im;

    modport master (
        output valid,
        output x0_re,
        output x0_im,
        output x1_re,
        output x1_im
    );

    modport slave (
        input valid,
        input x0_re,
        input x0_im,
        input x1_re,
        input x1_im
    );
endinterface

// File: rtl/mdc_delay_switch_stage.sv
// R2MDC inter-butterfly reorder stage: D-deep pre-delay on path 1,
// commutator switch toggling every D beats, D-deep post-delay on path 0.
// Ports:
//   CLK     : rising-edge clock
//   RST     : synchronous reset, active-high (wins over a same-cycle beat)
//   in_bus  : slave pair bus (valid, in0 = x0_*, in1 = x1_*)
//   out_bus : master pair bus (registered out_valid, out0 = x0_*, out1 = x1_*)
//   sel     : commutator state that the next beat will use
module mdc_delay_switch_stage #(
    parameter int DW    = 16,
    parameter int DELAY = 2
) (
    input  logic CLK,
    input  logic RST,
    mdc_delay_switch_stage_if.slave  in_bus,
    mdc_delay_switch_stage_if.master out_bus,
    output logic sel
);

    localparam int SW = 2 * DW;
    localparam int CW = $clog2(2 * DELAY);
    localparam int FW = $clog2(2 * DELAY + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(DELAY);
    localparam logic [FW-1:0] FILL_FULL = FW'(2 * DELAY);

    // A beat only counts when reset is not asserted in the same cycle.
    logic beat;

    logic [CW-1:0] cnt;
    logic [FW-1:0] fill;

    // Samples are carried as {re, im} so both halves move together.
    logic [SW-1:0] pre_q  [DELAY];
    logic [SW-1:0] post_q [DELAY];

    logic [SW-1:0] a;
    logic [SW-1:0] b;
    logic [SW-1:0] bd;
    logic [SW-1:0] p;
    logic [SW-1:0] q;
    logic [SW-1:0] o0;

    assign beat = in_bus.valid & ~RST;

    assign a  = {in_bus.x0_re, in_bus.x0_im};
    assign b  = {in_bus.x1_re, in_bus.x1_im};
    assign bd = pre_q[DELAY-1];
    assign o0 = post_q[DELAY-1];

    // Second half of each 2D-beat period swaps the two paths.
    assign sel = (cnt >= CNT_HALF);

    always_comb begin
        p = a;
        q = bd;
        if (sel) begin
            p = bd;
            q = a;
        end
    end

    // Delay lines are deliberately not reset: stale contents stay masked
    // by the fill counter until 2D fresh beats have pushed them out.
    always_ff @(posedge CLK) begin
        if (beat) begin
            pre_q[0]  <= b;
            post_q[0] <= p;
            for (int i = 1; i < DELAY; i++) begin
                pre_q[i]  <= pre_q[i-1];
                post_q[i] <= post_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            fill <= '0;
        end else if (in_bus.valid) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (fill != FILL_FULL) begin
                fill <= fill + FW'(1);
            end
        end
    end

    // Outputs refresh on every beat; valid only once both delay lines
    // hold data from this run (fill has reached 2D before this beat).
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_bus.valid <= 1'b0;
            out_bus.x0_re <= '0;
            out_bus.x0_im <= '0;
            out_bus.x1_re <= '0;
            out_bus.x1_im <= '0;
        end else if (in_bus.valid) begin
            out_bus.valid                  <= (fill == FILL_FULL);
            {out_bus.x0_re, out_bus.x0_im} <= o0;
            {out_bus.x1_re, out_bus.x1_im} <= q;
        end else begin
            out_bus.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mdc_delay_switch_stage.sv
// Directed bench for mdc_delay_switch_stage at D=2, D=1 and D=4,
// with a history-based golden model for the D=4 random stream.
module tb_mdc_delay_switch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2, rst1, rst4;
    logic sel2, sel1, sel4;

    mdc_delay_switch_stage_if #(.DW(16)) in2 ();
    mdc_delay_switch_stage_if #(.DW(16)) out2 ();
    mdc_delay_switch_stage_if #(.DW(8))  in1 ();
    mdc_delay_switch_stage_if #(.DW(8))  out1 ();
    mdc_delay_switch_stage_if #(.DW(16)) in4 ();
    mdc_delay_switch_stage_if #(.DW(16)) out4 ();

    mdc_delay_switch_stage #(.DW(16), .DELAY(2)) u_d2 (
        .CLK(clk), .RST(rst2), .in_bus(in2), .out_bus(out2), .sel(sel2)
    );
    mdc_delay_switch_stage #(.DW(8), .DELAY(1)) u_d1 (
        .CLK(clk), .RST(rst1), .in_bus(in1), .out_bus(out1), .sel(sel1)
    );
    mdc_delay_switch_stage #(.DW(16), .DELAY(4)) u_d4 (
        .CLK(clk), .RST(rst4), .in_bus(in4), .out_bus(out4), .sel(sel4)
    );

    int checks = 0;
    int errors = 0;

    // D=2 stream: a_k = k / 1000+k, b_k = 100+k / 2000+k (re / im)
    function automatic logic [15:0] a_re(input int k); return 16'(k);        endfunction
    function automatic logic [15:0] a_im(input int k); return 16'(1000 + k); endfunction
    function automatic logic [15:0] b_re(input int k); return 16'(100 + k);  endfunction
    function automatic logic [15:0] b_im(input int k); return 16'(2000 + k); endfunction

    // Expected {out0_re,out0_im,out1_re,out1_im} after beat k, D=2:
    // pairs (b_{k-4}, b_{k-2}) then (a_{k-2}, a_k), alternating every 2 beats.
    function automatic logic [63:0] exp2(input int k);
        if (((k / 2) % 2) == 0)
            return {b_re(k-4), b_im(k-4), b_re(k-2), b_im(k-2)};
        else
            return {a_re(k-2), a_im(k-2), a_re(k), a_im(k)};
    endfunction

    function automatic logic sel2_after(input int k);
        return 1'(((k + 1) / 2) % 2);
    endfunction

    // D=1 stream: a_k = k / 0x10+k, b_k = 0x80+k / 0xC0+k
    function automatic logic [31:0] exp1(input int k);
        if ((k % 2) == 0)
            return {8'(8'h80 + k - 2), 8'(8'hC0 + k - 2), 8'(8'h80 + k - 1), 8'(8'hC0 + k - 1)};
        else
            return {8'(k - 1), 8'(8'h10 + k - 1), 8'(k), 8'(8'h10 + k)};
    endfunction

    task automatic cyc2(input logic v, input int k);
        @(negedge clk);
        in2.valid = v;
        if (v) begin
            in2.x0_re = a_re(k); in2.x0_im = a_im(k);
            in2.x1_re = b_re(k); in2.x1_im = b_im(k);
        end else begin
            in2.x0_re = 16'hdead; in2.x0_im = 16'hbeef;
            in2.x1_re = 16'hcafe; in2.x1_im = 16'hf00d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input logic v, input int k);
        @(negedge clk);
        in1.valid = v;
        in1.x0_re = 8'(k);          in1.x0_im = 8'(8'h10 + k);
        in1.x1_re = 8'(8'h80 + k);  in1.x1_im = 8'(8'hC0 + k);
        @(posedge clk);
        #1;
    endtask

    task automatic reset2;
        @(negedge clk);
        rst2 = 1'b1;
        in2.valid = 1'b0;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst2 = 1'b1; rst1 = 1'b1; rst4 = 1'b1;
        in2.valid = 1'b0; in1.valid = 1'b0; in4.valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out2.valid !== 1'b0 || sel2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_d2_ctl: valid=%b sel=%b, expected 0 0", out2.valid, sel2);
        end
        checks++;
        if ({out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im} !== 64'h0) begin
            errors++;
            $display("FAIL reset_d2_data: got %h expected 0",
                     {out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im});
        end
        checks++;
        if (out1.valid !== 1'b0 || sel1 !== 1'b0 ||
            {out1.x0_re, out1.x0_im, out1.x1_re, out1.x1_im} !== 32'h0) begin
            errors++;
            $display("FAIL reset_d1: valid=%b sel=%b data=%h expected all 0", out1.valid, sel1,
                     {out1.x0_re, out1.x0_im, out1.x1_re, out1.x1_im});
        end
        checks++;
        if (out4.valid !== 1'b0 || sel4 !== 1'b0 ||
            {out4.x0_re, out4.x0_im, out4.x1_re, out4.x1_im} !== 64'h0) begin
            errors++;
            $display("FAIL reset_d4: valid=%b sel=%b data=%h expected all 0", out4.valid, sel4,
                     {out4.x0_re, out4.x0_im, out4.x1_re, out4.x1_im});
        end
        rst2 = 1'b0; rst1 = 1'b0; rst4 = 1'b0;
    endtask

    task automatic test_stream;
        reset2();
        for (int k = 0; k < 16; k++) begin
            cyc2(1'b1, k);
            checks++;
            if (out2.valid !== (k >= 4)) begin
                errors++;
                $display("FAIL stream_valid k=%0d: got %b expected %b", k, out2.valid, k >= 4);
            end
            if (k >= 4) begin
                checks++;
                if ({out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im} !== exp2(k)) begin
                    errors++;
                    $display("FAIL stream_data k=%0d: got %h expected %h", k,
                             {out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im}, exp2(k));
                end
            end
            checks++;
            if (sel2 !== sel2_after(k)) begin
                errors++;
                $display("FAIL stream_sel k=%0d: got %b expected %b", k, sel2, sel2_after(k));
            end
        end
    endtask

    task automatic test_gaps;
        reset2();
        for (int k = 0; k < 12; k++) begin
            cyc2(1'b1, k);
            checks++;
            if (out2.valid !== (k >= 4)) begin
                errors++;
                $display("FAIL gaps_valid k=%0d: got %b expected %b", k, out2.valid, k >= 4);
            end
            if (k >= 3) begin
                checks++;
                if ({out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im} !== exp2(k)) begin
                    errors++;
                    $display("FAIL gaps_data k=%0d: got %h expected %h", k,
                             {out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im}, exp2(k));
                end
            end
            if (k == 3 || k == 6) begin
                for (int g = 0; g < 3; g++) begin
                    cyc2(1'b0, k);
                    checks++;
                    if (out2.valid !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_valid k=%0d g=%0d: got %b expected 0", k, g, out2.valid);
                    end
                    checks++;
                    if ({out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im} !== exp2(k)) begin
                        errors++;
                        $display("FAIL gap_hold k=%0d g=%0d: got %h expected %h", k, g,
                                 {out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im}, exp2(k));
                    end
                    checks++;
                    if (sel2 !== sel2_after(k)) begin
                        errors++;
                        $display("FAIL gap_sel k=%0d: got %b expected %b", k, sel2, sel2_after(k));
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        reset2();
        for (int k = 0; k < 10; k++) cyc2(1'b1, k);
        checks++;
        if (out2.valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: valid got %b expected 1", out2.valid);
        end
        @(negedge clk);
        rst2 = 1'b1;
        in2.valid = 1'b1;
        in2.x0_re = a_re(10); in2.x0_im = a_im(10);
        in2.x1_re = b_re(10); in2.x1_im = b_im(10);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        checks++;
        if (out2.valid !== 1'b0 || sel2 !== 1'b0 ||
            {out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im} !== 64'h0) begin
            errors++;
            $display("FAIL midrst_clear: valid=%b sel=%b data=%h expected all 0", out2.valid, sel2,
                     {out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im});
        end
        for (int k = 0; k < 12; k++) begin
            cyc2(1'b1, k);
            checks++;
            if (out2.valid !== (k >= 4)) begin
                errors++;
                $display("FAIL midrst_valid k=%0d: got %b expected %b", k, out2.valid, k >= 4);
            end
            if (k >= 4) begin
                checks++;
                if ({out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im} !== exp2(k)) begin
                    errors++;
                    $display("FAIL midrst_data k=%0d: got %h expected %h", k,
                             {out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im}, exp2(k));
                end
            end
        end
    endtask

    task automatic test_d1;
        @(negedge clk);
        rst1 = 1'b1;
        in1.valid = 1'b0;
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc1(1'b1, k);
            checks++;
            if (out1.valid !== (k >= 2)) begin
                errors++;
                $display("FAIL d1_valid k=%0d: got %b expected %b", k, out1.valid, k >= 2);
            end
            if (k >= 2) begin
                checks++;
                if ({out1.x0_re, out1.x0_im, out1.x1_re, out1.x1_im} !== exp1(k)) begin
                    errors++;
                    $display("FAIL d1_data k=%0d: got %h expected %h", k,
                             {out1.x0_re, out1.x0_im, out1.x1_re, out1.x1_im}, exp1(k));
                end
            end
            checks++;
            if (sel1 !== 1'((k + 1) % 2)) begin
                errors++;
                $display("FAIL d1_sel k=%0d: got %b expected %b", k, sel1, 1'((k + 1) % 2));
            end
        end
        in1.valid = 1'b0;
    endtask

    task automatic test_random_d4;
        logic [31:0] hb[$];
        logic [31:0] hp[$];
        logic [31:0] a, b, bd, p, q, o0;
        logic [63:0] last;
        logic        known;
        logic        v;
        logic        sm;
        int          nb;
        @(negedge clk);
        rst4 = 1'b1;
        in4.valid = 1'b0;
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        nb = 0;
        known = 1'b0;
        last = '0;
        for (int c = 0; c < 6000 && nb < 1000; c++) begin
            v = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            in4.valid = v;
            {in4.x0_re, in4.x0_im} = a;
            {in4.x1_re, in4.x1_im} = b;
            @(posedge clk);
            #1;
            if (v) begin
                sm = 1'((nb / 4) % 2);
                bd = (nb >= 4) ? hb[nb-4] : 'x;
                p  = sm ? bd : a;
                q  = sm ? a : bd;
                o0 = (nb >= 4) ? hp[nb-4] : 'x;
                hb.push_back(b);
                hp.push_back(p);
                checks++;
                if (out4.valid !== (nb >= 8)) begin
                    errors++;
                    $display("FAIL rnd_valid beat=%0d: got %b expected %b", nb, out4.valid, nb >= 8);
                end
                if (nb >= 8) begin
                    checks++;
                    if (out4.x0_re !== o0[31:16]) begin
                        errors++;
                        $display("FAIL rnd_o0_re beat=%0d: got %h expected %h", nb, out4.x0_re, o0[31:16]);
                    end
                    checks++;
                    if (out4.x0_im !== o0[15:0]) begin
                        errors++;
                        $display("FAIL rnd_o0_im beat=%0d: got %h expected %h", nb, out4.x0_im, o0[15:0]);
                    end
                    checks++;
                    if (out4.x1_re !== q[31:16]) begin
                        errors++;
                        $display("FAIL rnd_o1_re beat=%0d: got %h expected %h", nb, out4.x1_re, q[31:16]);
                    end
                    checks++;
                    if (out4.x1_im !== q[15:0]) begin
                        errors++;
                        $display("FAIL rnd_o1_im beat=%0d: got %h expected %h", nb, out4.x1_im, q[15:0]);
                    end
                    last = {o0, q};
                    known = 1'b1;
                end
                nb++;
            end else begin
                checks++;
                if (out4.valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_idle_valid beat=%0d: got %b expected 0", nb, out4.valid);
                end
                if (known) begin
                    checks++;
                    if ({out4.x0_re, out4.x0_im, out4.x1_re, out4.x1_im} !== last) begin
                        errors++;
                        $display("FAIL rnd_hold beat=%0d: got %h expected %h", nb,
                                 {out4.x0_re, out4.x0_im, out4.x1_re, out4.x1_im}, last);
                    end
                end
            end
            checks++;
            if (sel4 !== 1'((nb / 4) % 2)) begin
                errors++;
                $display("FAIL rnd_sel beat=%0d: got %b expected %b", nb, sel4, 1'((nb / 4) % 2));
            end
        end
        checks++;
        if (nb < 1000) begin
            errors++;
            $display("FAIL rnd_budget: got %0d beats expected 1000", nb);
        end
        in4.valid = 1'b0;
    endtask

    task automatic test_rst_with_valid;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst2 = 1'b1;
            in2.valid = 1'b1;
            in2.x0_re = a_re(50 + i); in2.x0_im = a_im(50 + i);
            in2.x1_re = b_re(50 + i); in2.x1_im = b_im(50 + i);
            @(posedge clk);
            #1;
            checks++;
            if (out2.valid !== 1'b0 || sel2 !== 1'b0) begin
                errors++;
                $display("FAIL rstv_hold i=%0d: valid=%b sel=%b expected 0 0", i, out2.valid, sel2);
            end
        end
        rst2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc2(1'b1, k);
            checks++;
            if (out2.valid !== (k >= 4)) begin
                errors++;
                $display("FAIL rstv_valid k=%0d: got %b expected %b", k, out2.valid, k >= 4);
            end
            if (k >= 4) begin
                checks++;
                if ({out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im} !== exp2(k)) begin
                    errors++;
                    $display("FAIL rstv_data k=%0d: got %h expected %h", k,
                             {out2.x0_re, out2.x0_im, out2.x1_re, out2.x1_im}, exp2(k));
                end
            end
        end
        in2.valid = 1'b0;
    endtask

    initial begin
        rst2 = 1'b1; rst1 = 1'b1; rst4 = 1'b1;
        in2.valid = 1'b0; in2.x0_re = '0; in2.x0_im = '0; in2.x1_re = '0; in2.x1_im = '0;
        in1.valid = 1'b0; in1.x0_re = '0; in1.x0_im = '0; in1.x1_re = '0; in1.x1_im = '0;
        in4.valid = 1'b0; in4.x0_re = '0; in4.x0_im = '0; in4.x1_re = '0; in4.x1_im = '0;
        test_reset();
        test_stream();
        test_gaps();
        test_mid_reset();
        test_d1();
        test_random_d4();
        test_rst_with_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
